// File: rtl/mem_access_pkg.sv
// Shared constants for the MEM stage: branch condition codes, access size
// encodings and the memory-transaction FSM states.
package mem_access_pkg;

  localparam logic [2:0] BR_EQ     = 3'd0;
  localparam logic [2:0] BR_GT     = 3'd1;
  localparam logic [2:0] BR_GE     = 3'd2;
  localparam logic [2:0] BR_NE     = 3'd3;
  localparam logic [2:0] BR_LT     = 3'd4;
  localparam logic [2:0] BR_LE     = 3'd5;
  localparam logic [2:0] BR_ALWAYS = 3'd6;
  localparam logic [2:0] BR_NEVER  = 3'd7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_FULL = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores (replicated data + byte enables) and lane
// extraction with sign/zero extension for loads. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [1:0]        st_size,
  input  logic [OFF_W-1:0]  st_offset,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_wdata,
  output logic [NB-1:0]     st_be,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [OFF_W-1:0]  ld_offset,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_mask = NB'(1);
      SZ_HALF: lane_mask = NB'(3);
      SZ_WORD: lane_mask = NB'(15);
      default: lane_mask = '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] data);
    case (size)
      SZ_BYTE: replicate = {NB{data[7:0]}};
      SZ_HALF: replicate = {(NB/2){data[15:0]}};
      SZ_WORD: replicate = {(NB/4){data[31:0]}};
      default: replicate = data;
    endcase
  endfunction

  // Size casts of signed operands sign-extend; unsigned ones zero-extend.
  function automatic logic [DATA_W-1:0] extend(input logic [1:0] size,
                                               input logic uns,
                                               input logic [DATA_W-1:0] data);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = data[7:0];
    h = data[15:0];
    w = data[31:0];
    case (size)
      SZ_BYTE: if (uns) extend = DATA_W'(data[7:0]);  else extend = DATA_W'(b);
      SZ_HALF: if (uns) extend = DATA_W'(data[15:0]); else extend = DATA_W'(h);
      SZ_WORD: if (uns) extend = DATA_W'(data[31:0]); else extend = DATA_W'(w);
      default: extend = data;
    endcase
  endfunction

  logic [DATA_W-1:0] ld_shifted;

  always_comb begin
    st_wdata   = replicate(st_size, st_data);
    st_be      = lane_mask(st_size) << st_offset;
    ld_shifted = ld_rdata >> {ld_offset, 3'b000};
    ld_data    = extend(ld_size, ld_unsigned, ld_shifted);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: branch resolution plus a req/ack data-memory port.
// Define MEM_ACCESS_UNIT_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them down.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic                alu_zero_i,
  input  logic [DATA_W-1:0]   alu_result_i,
  input  logic                branch_i,
  input  logic [2:0]          branch_type_i,
  input  logic                memread_i,
  input  logic                memwrite_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [DATA_W-1:0]   store_data_i,
  output logic                branch_taken_o,
  output logic                stall_o,
  output logic [DATA_W-1:0]   load_data_o,
  output logic                load_valid_o,
  output logic                misalign_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  output logic [DATA_W/8-1:0] dmem_be_o,
  input  logic                dmem_ack_i,
  input  logic [DATA_W-1:0]   dmem_rdata_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: align_mask = '0;
      SZ_HALF: align_mask = OFF_W'(1);
      SZ_WORD: align_mask = OFF_W'(3);
      default: align_mask = '1;
    endcase
  endfunction

  state_e            state, state_nxt;
  logic              busy, memop, trap, accept, load_done, cond, sign;
  logic [OFF_W-1:0]  off_raw, off_al;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic [NB-1:0]     st_be;

  logic [ADDR_W-1:0] addr_p1;
  logic              we_p1, uns_p1;
  logic [NB-1:0]     be_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [1:0]        size_p1;
  logic [OFF_W-1:0]  off_p1;
  logic [DATA_W-1:0] load_data_p2;
  logic              vld_p2;

  always_comb begin
    sign = alu_result_i[DATA_W-1];
    case (branch_type_i)
      BR_EQ:     cond = alu_zero_i;
      BR_GT:     cond = ~sign & ~alu_zero_i;
      BR_GE:     cond = ~sign;
      BR_NE:     cond = ~alu_zero_i;
      BR_LT:     cond = sign;
      BR_LE:     cond = sign | alu_zero_i;
      BR_ALWAYS: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
    branch_taken_o = valid_i & branch_i & cond;
  end

  assign busy    = (state == ST_BUSY);
  assign memop   = valid_i & (memread_i | memwrite_i);
  assign off_raw = alu_result_i[OFF_W-1:0];
  assign off_al  = off_raw & ~align_mask(size_i);

`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
  logic mis_p2;
  assign trap       = memop & (|(off_raw & align_mask(size_i)));
  assign misalign_o = mis_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) mis_p2 <= 1'b0;
    else       mis_p2 <= ~busy & trap;
  end
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign accept    = ~busy & memop & ~trap;
  assign load_done = busy & dmem_ack_i & ~we_p1;
  assign stall_o   = accept | (busy & ~dmem_ack_i);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)     state_nxt = ST_BUSY;
      ST_BUSY: if (dmem_ack_i) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .st_size     (size_i),
    .st_offset   (off_al),
    .st_data     (store_data_i),
    .st_wdata    (st_wdata),
    .st_be       (st_be),
    .ld_size     (size_p1),
    .ld_unsigned (uns_p1),
    .ld_offset   (off_p1),
    .ld_rdata    (dmem_rdata_i),
    .ld_data     (ld_data)
  );

  // p1: request captured at acceptance, held stable while BUSY
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_p1  <= '0;
      we_p1    <= 1'b0;
      be_p1    <= '0;
      wdata_p1 <= '0;
      size_p1  <= SZ_BYTE;
      uns_p1   <= 1'b0;
      off_p1   <= '0;
    end else if (accept) begin
      addr_p1  <= {alu_result_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      we_p1    <= memwrite_i;
      be_p1    <= st_be;
      wdata_p1 <= st_wdata;
      size_p1  <= size_i;
      uns_p1   <= unsigned_i;
      off_p1   <= off_al;
    end
  end

  // p2: extended load result registered on ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2       <= 1'b0;
      load_data_p2 <= '0;
    end else begin
      vld_p2 <= load_done;
      if (load_done) load_data_p2 <= ld_data;
    end
  end

  assign dmem_req_o   = busy;
  assign dmem_we_o    = busy & we_p1;
  assign dmem_addr_o  = addr_p1;
  assign dmem_wdata_o = wdata_p1;
  assign dmem_be_o    = be_p1;
  assign load_data_o  = load_data_p2;
  assign load_valid_o = vld_p2;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed memory ops push expected
// requests/loads, a negedge monitor pops and compares them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, alu_zero = 1'b0, branch = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0, rdata = '0;
  logic [2:0]  branch_type = '0;
  logic        memread = 1'b0, memwrite = 1'b0, uns = 1'b0, ack = 1'b0;
  logic [1:0]  size = '0;
  logic        branch_taken, stall, load_valid, misalign, req, we;
  logic [31:0] load_data, addr, wdata;
  logic [3:0]  be;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .alu_zero_i(alu_zero),
    .alu_result_i(alu_result), .branch_i(branch), .branch_type_i(branch_type),
    .memread_i(memread), .memwrite_i(memwrite), .size_i(size),
    .unsigned_i(uns), .store_data_i(store_data), .branch_taken_o(branch_taken),
    .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid),
    .misalign_o(misalign), .dmem_req_o(req), .dmem_we_o(we),
    .dmem_addr_o(addr), .dmem_wdata_o(wdata), .dmem_be_o(be),
    .dmem_ack_i(ack), .dmem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];
  int          checks = 0, failures = 0;
  int          req_cnt = 0, mis_pending = 0;
  logic        exp_lv = 1'b0;
  req_t        mon_e;
  logic [31:0] mon_mask, mon_ld;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      req_cnt = 0;
      exp_lv  = 1'b0;
    end else begin
      if (exp_lv || load_valid) begin
        check("load_valid", load_valid, exp_lv);
        if (load_valid) begin
          check("load_q_nonempty", load_q.size() != 0, 1);
          if (load_q.size() != 0) begin
            mon_ld = load_q.pop_front();
            check("load_data", load_data, mon_ld);
          end
        end
      end
      exp_lv = 1'b0;
      if (misalign) begin
        check("misalign_expected", mis_pending > 0, 1);
        if (mis_pending > 0) mis_pending--;
      end
      if (req) begin
        req_cnt++;
        if (ack) begin
          check("req_q_nonempty", req_q.size() != 0, 1);
          if (req_q.size() != 0) begin
            mon_e = req_q.pop_front();
            check("req_addr", addr, mon_e.addr);
            check("req_we", we, mon_e.we);
            check("req_be", be, mon_e.be);
            check("req_cycles", req_cnt, mon_e.cycles);
            check("stall_in_ack", stall, 0);
            if (mon_e.we) begin
              for (int i = 0; i < 4; i++) mon_mask[8*i +: 8] = {8{mon_e.be[i]}};
              check("req_wdata", wdata & mon_mask, mon_e.wdata & mon_mask);
            end
            if (!we) exp_lv = 1'b1;
          end
          req_cnt = 0;
        end
      end
    end
  end

  // Caller positions just after a rising edge; task returns at the same phase.
  task automatic mem_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] a, input logic [31:0] sd,
                        input int waits, input logic [31:0] rd_data,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_load);
    req_t r;
    r.addr = e_addr; r.we = wr; r.be = e_be; r.wdata = e_wdata; r.cycles = waits + 1;
    req_q.push_back(r);
    if (!wr) load_q.push_back(e_load);
    valid = 1'b1; memread = rd; memwrite = wr; size = sz; uns = un;
    alu_result = a; store_data = sd;
    @(negedge clk);
    check("stall_accept", stall, 1);
    check("req_idle_accept", req, 0);
    @(posedge clk); #1;
    valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("stall_wait", stall, 1);
      @(posedge clk); #1;
    end
    ack = 1'b1; rdata = rd_data;
    @(negedge clk);
    @(posedge clk); #1;
    ack = 1'b0; rdata = '0;
  endtask

  logic [31:0] bvals[3] = '{32'h0, 32'h5, 32'hFFFFFFFB};
  logic [7:0]  bexp[3]  = '{8'h65, 8'h4E, 8'h78};
  logic [7:0]  be_row;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", req, 0);
    check("rst_we", we, 0);
    check("rst_load_valid", load_valid, 0);
    check("rst_misalign", misalign, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_be", be, 0);
    check("rst_load_data", load_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Branch resolution table
    valid = 1'b1; branch = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 8; c++) begin
        branch_type = 3'(c);
        alu_result  = bvals[v];
        alu_zero    = (bvals[v] == 32'h0);
        be_row      = bexp[v];
        @(negedge clk);
        check($sformatf("branch_c%0d_v%0d", c, v), branch_taken, be_row[c]);
        @(posedge clk); #1;
      end
    end
    check("branch_no_stall", stall, 0);
    branch_type = 3'd6; branch = 1'b0;
    @(negedge clk);
    check("branch_i_low", branch_taken, 0);
    @(posedge clk); #1;
    branch = 1'b1; valid = 1'b0;
    @(negedge clk);
    check("valid_low_branch", branch_taken, 0);
    @(posedge clk); #1;
    branch = 1'b0; alu_zero = 1'b0;

    // memread with valid_i low is not a memop
    memread = 1'b1; alu_result = 32'h200;
    @(negedge clk);
    check("novalid_stall", stall, 0);
    @(posedge clk); #1;
    memread = 1'b0;
    @(negedge clk);
    check("novalid_req", req, 0);
    @(posedge clk); #1;

    mem_op(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 2, 32'h0,
           32'h100, 4'hF, 32'hDEADBEEF, 32'h0);
    mem_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 0, 32'h80000000,
           32'h100, 4'h8, 32'h0, 32'hFFFFFF80);
    mem_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 32'h80000000,
           32'h100, 4'h8, 32'h0, 32'h00000080);
    mem_op(0, 1, 2'd1, 0, 32'h102, 32'h00001234, 0, 32'h0,
           32'h100, 4'hC, 32'h12340000, 32'h0);
    mem_op(0, 1, 2'd0, 0, 32'h101, 32'h000000A5, 1, 32'h0,
           32'h100, 4'h2, 32'h0000A500, 32'h0);
    mem_op(1, 0, 2'd1, 0, 32'h102, 32'h0, 0, 32'hBEEF0000,
           32'h100, 4'hC, 32'h0, 32'hFFFFBEEF);
    mem_op(1, 0, 2'd1, 1, 32'h102, 32'h0, 0, 32'hBEEF0000,
           32'h100, 4'hC, 32'h0, 32'h0000BEEF);
    mem_op(1, 0, 2'd2, 0, 32'h104, 32'h0, 2, 32'h12345678,
           32'h104, 4'hF, 32'h0, 32'h12345678);
    mem_op(1, 1, 2'd3, 0, 32'h10C, 32'hCAFEF00D, 0, 32'h0,
           32'h10C, 4'hF, 32'hCAFEF00D, 32'h0);

`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
    valid = 1'b1; memread = 1'b1; size = 2'd1; uns = 1'b0; alu_result = 32'h101;
    @(negedge clk);
    check("mis_stall", stall, 0);
    check("mis_req", req, 0);
    mis_pending++;
    @(posedge clk); #1;
    valid = 1'b0; memread = 1'b0;
    @(negedge clk);
    check("mis_no_req", req, 0);
    @(posedge clk); #1;
`else
    mem_op(1, 0, 2'd1, 0, 32'h101, 32'h0, 0, 32'h00008001,
           32'h100, 4'h3, 32'h0, 32'hFFFF8001);
`endif

    // Reset while BUSY, then a late ack
    valid = 1'b1; memread = 1'b1; size = 2'd2; uns = 1'b0; alu_result = 32'h108;
    @(negedge clk);
    check("rstbusy_accept_stall", stall, 1);
    @(posedge clk); #1;
    valid = 1'b0; memread = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstbusy_req_before", req, 1);
    @(posedge clk); #1;
    ack = 1'b1; rdata = 32'h55AA55AA;
    @(negedge clk);
    check("rstbusy_req", req, 0);
    check("rstbusy_addr", addr, 0);
    check("rstbusy_be", be, 0);
    check("rstbusy_we", we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("late_ack_req", req, 0);
    check("late_ack_stall", stall, 0);
    @(posedge clk); #1;
    ack = 1'b0; rdata = '0;
    @(negedge clk);
    check("late_ack_no_load", load_valid, 0);
    check("late_ack_load_data", load_data, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("load_q_drained", load_q.size(), 0);
    check("misalign_drained", mis_pending, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised MEM pipeline stage: resolves conditional branches from the ALU flags and performs data-memory loads/stores through a variable-latency request/acknowledge port, with byte/halfword/word access, lane steering and sign/zero extension. Sits between EX/MEM and MEM/WB registers; stalls the pipeline while a memory transaction is outstanding.

## Interface
- DATA_W, 32: datapath width; power of two, ≥32.
- ADDR_W, 32: data-memory address width.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  instruction in MEM is valid.
- alu_zero_i  in  1  ALU zero flag.
- alu_result_i  in  DATA_W  ALU result; memory address (low ADDR_W bits) or compare difference.
- branch_i  in  1  instruction is a branch.
- branch_type_i  in  3  branch condition code.
- memread_i / memwrite_i  in  1 each  load / store request.
- size_i  in  2  0 byte, 1 half, 2 word(32b), 3 full DATA_W.
- unsigned_i  in  1  zero-extend loads when 1.
- store_data_i  in  DATA_W  store data (right-aligned).
- branch_taken_o  out  1  branch taken.
- stall_o  out  1  hold upstream stages.
- load_data_o  out  DATA_W  extended load result.
- load_valid_o  out  1  one-cycle pulse, load_data_o valid.
- misalign_o  out  1  misaligned access trap (MEM_ACCESS_UNIT_MISALIGN_TRAP_EN only).
- dmem_req_o, dmem_we_o  out  1 each  request / write enable.
- dmem_addr_o  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero).
- dmem_wdata_o  out  DATA_W  lane-steered store data.
- dmem_be_o  out  DATA_W/8  byte enables.
- dmem_ack_i  in  1  transaction complete.
- dmem_rdata_i  in  DATA_W  read data, valid with ack.

## Operation
- Branch: sign = alu_result_i[DATA_W-1]; codes 0 beq zero, 1 bgt ~sign&~zero, 2 bge ~sign, 3 bne ~zero, 4 blt sign, 5 ble sign|zero, 6 always, 7 never. branch_taken_o = valid_i & branch_i & cond, combinational, independent of FSM state.
- Memop = valid_i & (memread_i | memwrite_i); memread_i and memwrite_i both set treated as store.
- FSM IDLE/BUSY. IDLE + memop: latch address, we, be, wdata, size, unsigned, offset; go BUSY. BUSY: dmem_req_o=1 with all dmem_* outputs stable until dmem_ack_i; on ack → IDLE.
- stall_o = (IDLE & memop) | (BUSY & ~dmem_ack_i).
- Store: byte lanes from offset = addr low bits; be = 1/3/0xF/all-ones shifted by offset; wdata replicated into selected lanes.
- Load: on ack with we=0, extract lanes at offset, sign- or zero-extend to DATA_W, register into load_data_o, pulse load_valid_o next cycle. Stores produce no load_valid_o.
- dmem_ack_i in IDLE ignored.
- Misalignment: offset not multiple of access size (half odd, word not 4-aligned, full not DATA_W/8-aligned).

## Timing
- Reset: state IDLE; dmem_req_o, dmem_we_o, load_valid_o, misalign_o = 0; dmem_addr_o, dmem_wdata_o, dmem_be_o, load_data_o = 0.
- Request issues cycle after acceptance; minimum latency accept→load_valid_o = 2 cycles (ack same cycle as first req), +1 per wait cycle.
- stall_o falls in the ack cycle; next memop accepted the following cycle (back-to-back allowed).
- rst_i mid-transaction: abandon, return IDLE, drop req; late ack ignored.

## Configuration
- MEM_ACCESS_UNIT_MISALIGN_TRAP_EN defined: misaligned memop in IDLE issues no request, pulses misalign_o one cycle (registered), stall_o low for it, no load_valid_o.
- Undefined: offset low bits truncated to access-size alignment; access proceeds; misalign_o tied 0.

## Structure
- mem_access_pkg: branch-code constants, size encodings, FSM state enum.
- Sub-module mem_lane_align: combinational store steering/byte-enable generation and load extraction/extension.

## Test plan
- All 8 branch codes with alu_result 0, 5, -5 (DATA_W=32) → taken per table; branch_i=0 or valid_i=0 → never taken.
- Word store 0xDEADBEEF at 0x100, ack after 3 cycles → req held 3 cycles, be=0xF, stall_o low in ack cycle.
- Byte load at 0x103, rdata 0x80000000, unsigned_i=0 → load_data_o 0xFFFFFF80; unsigned_i=1 → 0x00000080.
- Half store 0x1234 at 0x102 → be=0xC, wdata[31:16]=0x1234.
- Half load at 0x101: with macro → misalign_o pulse, no req; without → address 0x100 accessed.
- Reset asserted in BUSY then ack → no load_valid_o, outputs at reset values.
